// File: rtl/input_debounce_pkg.sv
// Shared constants and width helpers for the input debouncer.
package input_debounce_pkg;

  localparam int DEBOUNCE_PRESCALE_DEFAULT = 1000;
  localparam int DEBOUNCE_STABLE_DEFAULT   = 4;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Per-bit counter must hold 0..STABLE_SAMPLES-1.
  function automatic int cnt_width(input int stable_samples);
    return clog2(stable_samples + 1);
  endfunction

  function automatic int presc_width(input int prescale);
    return (prescale > 1) ? clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/input_debounce_lane.sv
// One debounced bit: two-flop synchroniser, stability counter, level and edge pulses.
module input_debounce_lane
  import input_debounce_pkg::*;
#(
  parameter int   STABLE_SAMPLES = DEBOUNCE_STABLE_DEFAULT,
  parameter logic RESET_BIT      = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enable,
  input  logic i_tick,
  input  logic i_data_in,
  output logic o_data_out,
  output logic o_rise,
  output logic o_fall
);

  localparam int             CW   = cnt_width(STABLE_SAMPLES);
  localparam logic [CW-1:0]  LAST = CW'(STABLE_SAMPLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;
  logic          w_differ;

  assign w_differ = r_sync2 ^ r_level;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= RESET_BIT;
      r_sync2 <= RESET_BIT;
      r_level <= RESET_BIT;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= i_data_in;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      if (!i_enable) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        if (!w_differ) begin
          r_cnt <= '0;
        end else if (r_cnt == LAST) begin
          // Accept the new level; pulse lines up with the data_out change.
          r_level <= r_sync2;
          r_cnt   <= '0;
          r_rise  <= r_sync2;
          r_fall  <= ~r_sync2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_data_out = r_level;
  assign o_rise     = r_rise;
  assign o_fall     = r_fall;

endmodule

// File: rtl/input_debounce.sv
// Debounced 16-bit input bus: shared sample-tick prescaler feeding WIDTH independent lanes.
module input_debounce
  import input_debounce_pkg::*;
#(
  parameter int               WIDTH          = 16,
  parameter int               PRESCALE       = DEBOUNCE_PRESCALE_DEFAULT,
  parameter int               STABLE_SAMPLES = DEBOUNCE_STABLE_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise_mask,
  output logic [WIDTH-1:0] fall_mask,
  output logic             tick
);

  localparam int            PW     = presc_width(PRESCALE);
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pcnt;
  logic          w_tick;

  // Gated by reset so tick stays low while held in reset even when PRESCALE==1.
  assign w_tick = reset & enable & (r_pcnt == P_LAST);
  assign tick   = w_tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pcnt <= '0;
    end else if (!enable || w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    input_debounce_lane #(
      .STABLE_SAMPLES(STABLE_SAMPLES),
      .RESET_BIT     (RESET_VALUE[g])
    ) u_lane (
      .i_clk     (clk),
      .i_rst_n   (reset),
      .i_enable  (enable),
      .i_tick    (w_tick),
      .i_data_in (data_in[g]),
      .o_data_out(data_out[g]),
      .o_rise    (rise_mask[g]),
      .o_fall    (fall_mask[g])
    );
  end

endmodule

// File: tb/tb_input_debounce.sv
// Self-checking bench: fast instance (PRESCALE=1, STABLE=4) and prescaled instance (PRESCALE=10, STABLE=2).
module tb_input_debounce;

  localparam int PR [2] = '{1, 10};
  localparam int SSV[2] = '{4, 2};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en_a = 1'b1, en_b = 1'b1;
  logic [15:0] din_a = 16'h0000, din_b = 16'h0000;
  logic [15:0] dout_a, rise_a, fall_a, dout_b, rise_b, fall_b;
  logic        tk_a, tk_b;

  always #5 clk = ~clk;

  input_debounce #(.WIDTH(16), .PRESCALE(1), .STABLE_SAMPLES(4), .RESET_VALUE(16'h0000)) dut_a (
    .clk(clk), .reset(reset), .enable(en_a), .data_in(din_a),
    .data_out(dout_a), .rise_mask(rise_a), .fall_mask(fall_a), .tick(tk_a));

  input_debounce #(.WIDTH(16), .PRESCALE(10), .STABLE_SAMPLES(2), .RESET_VALUE(16'h0000)) dut_b (
    .clk(clk), .reset(reset), .enable(en_b), .data_in(din_b),
    .data_out(dout_b), .rise_mask(rise_b), .fall_mask(fall_b), .tick(tk_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h time=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a level is accepted once the last STABLE sampled values all disagree with it.
  logic [15:0] m_s1[2], m_s2[2], m_out[2], m_rise[2], m_fall[2];
  int          m_ecnt[2];
  bit          m_hist[2][16][$];

  function automatic bit all_differ(input int d, input int i);
    for (int k = 0; k < m_hist[d][i].size(); k++)
      if (m_hist[d][i][k] == m_out[d][i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset(input int d);
    m_s1[d] = '0; m_s2[d] = '0; m_out[d] = '0;
    m_rise[d] = '0; m_fall[d] = '0; m_ecnt[d] = 0;
    for (int i = 0; i < 16; i++) m_hist[d][i].delete();
  endtask

  task automatic m_step(input int d, input logic en, input logic [15:0] din);
    bit tk;
    tk = en && ((m_ecnt[d] % PR[d]) == PR[d] - 1);
    m_rise[d] = '0;
    m_fall[d] = '0;
    if (tk) begin
      for (int i = 0; i < 16; i++) begin
        m_hist[d][i].push_back(m_s2[d][i]);
        if (m_hist[d][i].size() > SSV[d]) void'(m_hist[d][i].pop_front());
        if (m_hist[d][i].size() == SSV[d] && all_differ(d, i)) begin
          m_out[d][i] = m_s2[d][i];
          if (m_s2[d][i]) m_rise[d][i] = 1'b1; else m_fall[d][i] = 1'b1;
          m_hist[d][i].delete();
        end
      end
    end
    if (!en) begin
      m_ecnt[d] = 0;
      for (int i = 0; i < 16; i++) m_hist[d][i].delete();
    end else begin
      m_ecnt[d]++;
    end
    m_s2[d] = m_s1[d];
    m_s1[d] = din;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_reset(0);
      m_reset(1);
    end else begin
      m_step(0, en_a, din_a);
      m_step(1, en_b, din_b);
    end
  end

  function automatic logic exp_tick(input int d, input logic en);
    return reset && en && ((m_ecnt[d] % PR[d]) == PR[d] - 1);
  endfunction

  task automatic mcheck();
    chk("model_a_out",  dout_a, m_out[0]);
    chk("model_a_rise", rise_a, m_rise[0]);
    chk("model_a_fall", fall_a, m_fall[0]);
    chk("model_a_tick", {15'b0, tk_a}, {15'b0, exp_tick(0, en_a)});
    chk("model_b_out",  dout_b, m_out[1]);
    chk("model_b_rise", rise_b, m_rise[1]);
    chk("model_b_fall", fall_b, m_fall[1]);
    chk("model_b_tick", {15'b0, tk_b}, {15'b0, exp_tick(1, en_b)});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    mcheck();
  endtask

  // Release-to-acceptance on the fast instance: FFFF lands on the 6th edge.
  task automatic lat_a();
    din_a = 16'hFFFF;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      chk("lat_a_out",  dout_a, (k >= 6) ? 16'hFFFF : 16'h0000);
      chk("lat_a_rise", rise_a, (k == 6) ? 16'hFFFF : 16'h0000);
    end
  endtask

  typedef struct {
    logic [15:0] din;
    logic [15:0] out;
    logic [15:0] rise;
    logic [15:0] fall;
  } vec_t;
  vec_t tbl[$];

  task automatic addv(input logic [15:0] din, input logic [15:0] out,
                      input logic [15:0] rise, input logic [15:0] fall, input int n);
    vec_t v;
    v.din = din; v.out = out; v.rise = rise; v.fall = fall;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  initial begin
    int  n;
    bit  ok;

    // Held in reset with inputs high.
    din_a = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("rst_a_out", dout_a, 16'h0000);
      chk("rst_a_rise", rise_a, 16'h0000);
      chk("rst_a_tick", {15'b0, tk_a}, 16'h0000);
    end
    reset = 1'b1;
    lat_a();

    // Async reset mid-window while data_out=FFFF and counters are running.
    din_a = 16'h0000;
    repeat (4) cyc();
    chk("pre_rst_a_out", dout_a, 16'hFFFF);
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst_a_out",  dout_a, 16'h0000);
    chk("async_rst_a_fall", fall_a, 16'h0000);
    chk("async_rst_a_tick", {15'b0, tk_a}, 16'h0000);
    repeat (2) cyc();
    reset = 1'b1;
    lat_a();

    din_a = 16'h0000;
    repeat (8) cyc();
    chk("settle_a_out", dout_a, 16'h0000);

    // Table: glitch rejection, accepted rise/fall, simultaneous rise+fall.
    addv(16'h0008, 16'h0000, 16'h0000, 16'h0000, 3);
    addv(16'h0000, 16'h0000, 16'h0000, 16'h0000, 7);
    addv(16'h0008, 16'h0000, 16'h0000, 16'h0000, 5);
    addv(16'h0008, 16'h0008, 16'h0008, 16'h0000, 1);
    addv(16'h0008, 16'h0008, 16'h0000, 16'h0000, 1);
    addv(16'h0000, 16'h0008, 16'h0000, 16'h0000, 5);
    addv(16'h0000, 16'h0000, 16'h0000, 16'h0008, 1);
    addv(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1);
    addv(16'h00FF, 16'h0000, 16'h0000, 16'h0000, 5);
    addv(16'h00FF, 16'h00FF, 16'h00FF, 16'h0000, 1);
    addv(16'h00FF, 16'h00FF, 16'h0000, 16'h0000, 1);
    addv(16'hFF00, 16'h00FF, 16'h0000, 16'h0000, 5);
    addv(16'hFF00, 16'hFF00, 16'hFF00, 16'h00FF, 1);
    addv(16'hFF00, 16'hFF00, 16'h0000, 16'h0000, 1);
    for (int r = 0; r < tbl.size(); r++) begin
      din_a = tbl[r].din;
      cyc();
      chk("tbl_out",  dout_a, tbl[r].out);
      chk("tbl_rise", rise_a, tbl[r].rise);
      chk("tbl_fall", fall_a, tbl[r].fall);
    end

    // Prescaled instance: tick period, 2-tick acceptance latency.
    n = 0;
    do begin cyc(); n++; end while (!tk_b && n < 20);
    chk("b_tick_found", {15'b0, tk_b}, 16'h0001);
    n = 0;
    do begin cyc(); n++; end while (!tk_b && n < 20);
    chk("b_tick_period", 16'(n), 16'd10);
    din_b = 16'h0001;
    n = 0;
    do begin cyc(); n++; end while (dout_b != 16'h0001 && n < 40);
    chk("b_latency", 16'(n), 16'd21);
    chk("b_rise", rise_b, 16'h0001);

    // Bounce back before the second tick: no change.
    din_b = 16'h0000;
    repeat (14) cyc();
    din_b = 16'h0001;
    ok = 1'b1;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (dout_b != 16'h0001) ok = 1'b0;
    end
    chk("b_bounce_hold", {15'b0, ok}, 16'h0001);

    // Enable freeze after one mismatching tick; a full window is needed afterwards.
    din_b = 16'h0000;
    repeat (6) cyc();
    en_b = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (dout_b != 16'h0001 || tk_b) ok = 1'b0;
    end
    chk("b_freeze", {15'b0, ok}, 16'h0001);
    en_b = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (k == 19) chk("b_reenable_wait", dout_b, 16'h0001);
      if (k == 20) begin
        chk("b_reenable_out",  dout_b, 16'h0000);
        chk("b_reenable_fall", fall_b, 16'h0001);
      end
    end

    // Random activity on both instances against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(5) == 0)  din_a = din_a ^ 16'($urandom & $urandom);
      if ($urandom_range(39) == 0) din_b = din_b ^ 16'($urandom & $urandom);
      if ($urandom_range(99) == 0) en_a = ~en_a;
      if ($urandom_range(149) == 0) en_b = ~en_b;
      if (i == 2000) begin
        #2 reset = 1'b0;
        #1 chk("rand_rst_a_out", dout_a, 16'h0000);
        chk("rand_rst_b_out", dout_b, 16'h0000);
      end
      if (i == 2002) reset = 1'b1;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
